// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared definitions: RV32M op encoding, muldiv FSM states, operand sign helpers
package definitions;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  function automatic logic md_is_div(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_a_signed(input md_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input md_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// rtl/muldiv_unit_step.sv - one combinational iteration: LSB-first add-shift multiply or
// MSB-first restoring compare-subtract-shift divide on magnitudes.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
  // Shifted partial remainder carries an extra bit so the compare never overflows.
  assign w_shift = {i_hi, i_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_b};

  always_comb begin
    o_hi = {1'b0, w_sum[XLEN:2], w_sum[1]};
    o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_div) begin
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shift[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[XLEN:1];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for Execute; busy while iterating,
// one-cycle Done pulse, fast path for divide-by-zero and signed overflow.
module muldiv_unit
  import definitions::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            MD_Start_E,
  input  logic [2:0]      MD_Op_E,
  input  logic [XLEN-1:0] MD_SrcA_E,
  input  logic [XLEN-1:0] MD_SrcB_E,
  input  logic            MD_Flush_E,
  output logic            MD_Busy_E,
  output logic            MD_Done_E,
  output logic [XLEN-1:0] MD_Result_E
);

  localparam int K  = XLEN / UNROLL;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       r_state;
  md_state_t       w_next;
  md_op_t          r_op;
  logic            r_neg;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_result;

  md_op_t          w_op;
  logic            w_sa, w_sb, w_neg, w_fast, w_b_zero, w_ovf;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_fast_quo, w_fast_rem;
  logic            w_accept, w_busy, w_done;

  assign w_op     = md_op_t'(MD_Op_E);
  assign w_sa     = md_a_signed(w_op) & MD_SrcA_E[XLEN-1];
  assign w_sb     = md_b_signed(w_op) & MD_SrcB_E[XLEN-1];
  assign w_mag_a  = w_sa ? -MD_SrcA_E : MD_SrcA_E;
  assign w_mag_b  = w_sb ? -MD_SrcB_E : MD_SrcB_E;
  // Unsigned ops already have both sign flags cleared, so only REM needs special handling.
  assign w_neg    = (w_op == MD_REM) ? w_sa : (w_sa ^ w_sb);
  assign w_b_zero = (MD_SrcB_E == '0);
  assign w_ovf    = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                    (MD_SrcA_E == MOST_NEG) && (MD_SrcB_E == '1);
  assign w_fast   = md_is_div(w_op) && (w_b_zero || w_ovf);
  assign w_fast_quo = w_b_zero ? '1 : MD_SrcA_E;
  assign w_fast_rem = w_b_zero ? MD_SrcA_E : '0;

  logic [XLEN-1:0] w_hi [UNROLL+1];
  logic [XLEN-1:0] w_lo [UNROLL+1];
  assign w_hi[0] = r_hi;
  assign w_lo[0] = r_lo;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_div (md_is_div(r_op)),
      .i_hi  (w_hi[g]),
      .i_lo  (w_lo[g]),
      .i_b   (r_b),
      .o_hi  (w_hi[g+1]),
      .o_lo  (w_lo[g+1])
    );
  end

  logic [2*XLEN-1:0] w_prod, w_prod_c;
  logic [XLEN-1:0]   w_quo_c, w_rem_c, w_result;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_c = r_neg ? -w_prod : w_prod;
  assign w_quo_c  = r_neg ? -r_lo : r_lo;
  assign w_rem_c  = r_neg ? -r_hi : r_hi;

  always_comb begin
    w_result = w_rem_c;
    case (r_op)
      MD_MUL:                     w_result = w_prod_c[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_result = w_prod_c[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:            w_result = w_quo_c;
      default:                    w_result = w_rem_c;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: w_accept = MD_Start_E;
      CALC: begin
        w_busy = 1'b1;
        if (r_count == '0) w_next = DONE;
      end
      DONE: begin
        w_done   = 1'b1;
        w_next   = IDLE;
        w_accept = MD_Start_E;
      end
      default: w_next = IDLE;
    endcase
    if (w_accept) w_next = w_fast ? DONE : CALC;
    if (MD_Flush_E) begin
      w_next   = IDLE;
      w_accept = 1'b0;
      w_done   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= w_op;
        r_b     <= w_mag_b;
        r_count <= CW'(K - 1);
        if (w_fast) begin
          r_hi  <= w_fast_rem;
          r_lo  <= w_fast_quo;
          r_neg <= 1'b0;
        end else begin
          r_hi  <= '0;
          r_lo  <= w_mag_a;
          r_neg <= w_neg;
        end
      end else if (r_state == CALC) begin
        r_hi    <= w_hi[UNROLL];
        r_lo    <= w_lo[UNROLL];
        r_count <= r_count - 1'b1;
      end
      if (w_done) r_result <= w_result;
    end
  end

  assign MD_Busy_E   = w_busy;
  assign MD_Done_E   = w_done;
  // The corrected value is visible in the Done cycle itself; afterwards the registered copy holds.
  assign MD_Result_E = w_done ? w_result : r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at UNROLL=1 and UNROLL=4
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .CLK(clk), .RST(rst), .MD_Start_E(start), .MD_Op_E(op), .MD_SrcA_E(a), .MD_SrcB_E(b),
    .MD_Flush_E(flush), .MD_Busy_E(busy1), .MD_Done_E(done1), .MD_Result_E(res1)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .CLK(clk), .RST(rst), .MD_Start_E(start), .MD_Op_E(op), .MD_SrcA_E(a), .MD_SrcB_E(b),
    .MD_Flush_E(flush), .MD_Busy_E(busy4), .MD_Done_E(done4), .MD_Result_E(res4)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts one operation and reports the cycle (1 = cycle after the start edge) in which Done appeared.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit sel4, output logic [31:0] res, output int dcyc, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    dcyc = -1; bcnt = 0; res = '0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (sel4 ? busy4 : busy1) bcnt++;
      if (sel4 ? done4 : done1) begin
        dcyc = n;
        res = sel4 ? res4 : res1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done1); end
    if (res1 !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", res1); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b want 0", busy4); end
  endtask

  task automatic test_mul();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, r, d, bc);
    checks += 4;
    if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got %h want ffffffeb", r); end
    if (d !== 33) begin errors++; $display("FAIL mul_latency got %0d want 33", d); end
    if (bc !== 32) begin errors++; $display("FAIL mul_busy_cycles got %0d want 32", bc); end
    repeat (3) @(negedge clk);
    if (res1 !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_hold got %h want ffffffeb", res1); end
  endtask

  task automatic test_mulh();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd1, 32'h80000000, 32'h80000000, 1'b0, r, d, bc);
    checks++;
    if (r !== 32'h40000000) begin errors++; $display("FAIL mulh got %h want 40000000", r); end
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, d, bc);
    checks++;
    if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", r); end
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, r, d, bc);
    checks++;
    if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd5, 32'd100, 32'd7, 1'b0, r, d, bc);
    checks += 2;
    if (r !== 32'd14) begin errors++; $display("FAIL divu got %h want 0000000e", r); end
    if (d !== 33) begin errors++; $display("FAIL divu_latency got %0d want 33", d); end
    run_op(3'd7, 32'd100, 32'd7, 1'b0, r, d, bc);
    checks++;
    if (r !== 32'd2) begin errors++; $display("FAIL remu got %h want 00000002", r); end
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 1'b0, r, d, bc);
    checks++;
    if (r !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got %h want fffffffd", r); end
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 1'b0, r, d, bc);
    checks++;
    if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffff", r); end
  endtask

  task automatic test_fast();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd4, 32'd5, 32'd0, 1'b0, r, d, bc);
    checks += 3;
    if (r !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_by0 got %h want ffffffff", r); end
    if (d !== 1) begin errors++; $display("FAIL div_by0_latency got %0d want 1", d); end
    if (bc !== 0) begin errors++; $display("FAIL div_by0_busy got %0d want 0", bc); end
    run_op(3'd7, 32'd5, 32'd0, 1'b0, r, d, bc);
    checks += 2;
    if (r !== 32'd5) begin errors++; $display("FAIL remu_by0 got %h want 00000005", r); end
    if (d !== 1) begin errors++; $display("FAIL remu_by0_latency got %0d want 1", d); end
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, d, bc);
    checks += 2;
    if (r !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h want 80000000", r); end
    if (d !== 1) begin errors++; $display("FAIL div_ovf_latency got %0d want 1", d); end
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, d, bc);
    checks += 2;
    if (r !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 00000000", r); end
    if (d !== 1) begin errors++; $display("FAIL rem_ovf_latency got %0d want 1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, r, d, bc);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", busy1); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy1); end
    if (done1 !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", done1); end
    if (res1 !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", res1); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int d, bc, dones;
    do_reset();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, r, d, bc);
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    flush = 1'b1;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      flush = 1'b0;
      if (done1) dones++;
    end
    checks += 3;
    if (dones !== 0) begin errors++; $display("FAIL flush_done got %0d want 0", dones); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy1); end
    if (res1 !== 32'hFFFFFFEB) begin errors++; $display("FAIL flush_result got %h want ffffffeb", res1); end
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_wins got busy %b want 0", busy1); end
  endtask

  task automatic test_unroll4();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd0, 32'd3, 32'd5, 1'b1, r, d, bc);
    checks += 3;
    if (r !== 32'd15) begin errors++; $display("FAIL u4_mul got %h want 0000000f", r); end
    if (d !== 9) begin errors++; $display("FAIL u4_mul_latency got %0d want 9", d); end
    if (bc !== 8) begin errors++; $display("FAIL u4_busy_cycles got %0d want 8", bc); end
    do_reset();
    run_op(3'd5, 32'd100, 32'd7, 1'b1, r, d, bc);
    checks++;
    if (r !== 32'd14) begin errors++; $display("FAIL u4_divu got %h want 0000000e", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int d, bc;
    do_reset();
    run_op(3'd0, 32'd3, 32'd5, 1'b1, r, d, bc);
    checks++;
    if (d !== 9) begin errors++; $display("FAIL b2b_first_latency got %0d want 9", d); end
    start = 1'b1; op = 3'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk);
    d = -1; r = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1 && busy4 !== 1'b1) begin
        errors++; $display("FAIL b2b_no_gap got busy %b want 1", busy4);
      end
      if (done4) begin d = n; r = res4; break; end
    end
    checks += 3;
    if (d !== 9) begin errors++; $display("FAIL b2b_second_latency got %0d want 9", d); end
    if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_second_result got %h want fffffffe", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_fast();
    test_reset_mid();
    test_flush();
    test_unroll4();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the Execute stage, adding RV32M support alongside the single-cycle ALU. It accepts one operation per start pulse and computes it over multiple cycles with a shift-add multiplier or a restoring divider. While it works, it holds a busy flag that the hazard unit uses to stall Fetch, Decode and Execute. Width and bits-per-cycle are parametrised, so the same block serves XLEN variants and faster configurations.

## Interface
- XLEN, 32, operand/result width; must be even and ≥ 8
- UNROLL, 1, iteration steps per cycle; must divide XLEN (1, 2, 4, 8)
- Clock and reset: one clock; reset is synchronous and active-high. Ports `CLK` and `RST`.
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  synchronous, active-high reset
- MD_Start_E  input  1  request; sampled only in IDLE or DONE
- MD_Op_E  input  3  operation, RV32M funct3 encoding (md_op_t)
- MD_SrcA_E  input  XLEN  multiplicand / dividend (rs1, after forwarding)
- MD_SrcB_E  input  XLEN  multiplier / divisor (rs2, after forwarding)
- MD_Flush_E  input  1  abort current operation (branch taken / flush)
- MD_Busy_E  output  1  high while in CALC
- MD_Done_E  output  1  one-cycle completion pulse
- MD_Result_E  output  XLEN  result; valid from the Done cycle and held until the next Done

## Operation
- States:
  - IDLE: waiting for a start.
  - CALC: iterating. K = XLEN/UNROLL cycles, counter from K-1 down to 0.
  - DONE: sign correction, register Result, pulse Done.
- Start accepted in IDLE or DONE: operands, op and sign flags are latched.
  - Normal path: next state CALC.
  - Fast path: next state DONE.
- Multiply path:
  - Operands are converted to magnitudes per op: MUL and MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned.
  - 2·XLEN-bit product is accumulated.
  - DONE negates the product if the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide path:
  - Restoring division on magnitudes, UNROLL quotient bits per cycle.
  - Quotient sign = sign(A) xor sign(B), for DIV only.
  - Remainder sign = sign(A), for REM only.
- Fast path (no CALC):
  - Divisor = 0: DIV/DIVU result = all ones; REM/REMU result = dividend.
  - Signed overflow (A = most-negative, B = -1): DIV result = A; REM result = 0.
- Start in CALC is ignored; the pipeline is stalled, so it does not occur legally.
- Flush in any state: next state IDLE, Done not asserted, Result retained.
  - Flush and Start in the same cycle: Flush wins, Start is dropped.
- RST: state IDLE, counter 0, internal registers 0.

## Timing
- Reset values: MD_Busy_E = 0, MD_Done_E = 0, MD_Result_E = 0.
- Start sampled at edge 0 (normal path):
  - Busy high during cycles 1…K.
  - Done high during cycle K+1 only, with Busy low in that cycle.
  - Latency is K+1 cycles: 33 at XLEN=32, UNROLL=1; 9 at UNROLL=4.
- Fast path: Done in cycle 1, Busy never asserted.
- Back-to-back: Start asserted in the DONE cycle begins the next operation with no idle gap.
- RST mid-CALC: outputs return to their reset values at the next edge and the operation is lost.
- Width rule: product register is 2·XLEN bits. Divider partial remainder is XLEN+1 bits, so the subtract-compare is done without overflow.

## Structure
- Add to the shared `definitions` package:
  - md_op_t enum: MD_MUL=0, MD_MULH=1, MD_MULHSU=2, MD_MULHU=3, MD_DIV=4, MD_DIVU=5, MD_REM=6, MD_REMU=7.
  - md_state_t enum: IDLE, CALC, DONE.
- Decoder changes: add an MD_En_E control bit. Result mux in Execute selects MD_Result_E over ALU_Out_E.
- Hazard unit stalls on MD_Busy_E | (MD_En_E & ~MD_Done_E).
- Sub-module `muldiv_step`: combinational single-bit step (add-shift or compare-subtract-shift). Instantiated UNROLL times in a generate chain.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), UNROLL=1 → Result 0xFFFFFFEB; Done in cycle 33; Busy high for exactly 32 cycles.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIVU 100/7 → 14, REMU → 2; DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, with Done in cycle 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, fast path.
- Start DIVU, then RST at cycle 10 → next cycle Busy=0, Done=0, Result=0. Start DIVU, then Flush at cycle 10 → no Done, previous Result retained.
- UNROLL=4: MUL 3 × 5 → 15 with Done in cycle 9. Back-to-back Start in the DONE cycle → second result 9 cycles later.
